// File: rtl/bcd_updown_display_if.sv
// Control and display bundle for bcd_updown_display.
// master: the controller that drives count control and watches the display.
// slave:  the counter/display block itself.
interface bcd_updown_display_if #(
  parameter int DIGITS = 8
);
  logic                  en;
  logic                  ud;
  logic [4:0]            rate;
  logic                  load;
  logic [3:0]            load_digit;
  logic [2:0]            digit_sel;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;

  modport master (
    output en, ud, rate, load, load_digit, digit_sel,
    input  count, tc, seg, dp, an
  );

  modport slave (
    input  en, ud, rate, load, load_digit, digit_sel,
    output count, tc, seg, dp, an
  );
endinterface

// File: rtl/bcd_updown_display.sv
// Multi-digit BCD up/down counter with a power-of-two prescaler, per-digit
// load, one-cycle wrap pulse, and a multiplexed active-low 7-segment display.
// Optional feature macro: LZ_BLANK_EN (blanks leading-zero positions above
// the most significant nonzero digit; position 0 always shows).
module bcd_updown_display #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  bcd_updown_display_if.slave bus
);
  localparam int          CW        = 4 * DIGITS;
  localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(DIGITS - 1);

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-BCD is dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [31:0]       pre_cnt_q, pre_cnt_d;
  logic              tick_s;
  logic [CW-1:0]     count_q, count_d;
  logic              tc_q, tc_d;
  logic [CW-1:0]     inc_s, dec_s;
  logic              inc_wrap_s, dec_wrap_s;
  logic [3:0]        ld_val_s;
  logic [31:0]       scan_cnt_q, scan_cnt_d;
  logic [2:0]        index_q, index_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        cur_digit_s;
  logic [2:0]        msnz_s;
  logic              blank_s;

  // Prescaler: tick once pre_cnt reaches 2^rate-1 (>= so a rate drop ticks at once).
  always_comb begin
    tick_s = (pre_cnt_q >= ((32'd1 << bus.rate) - 32'd1));
    if (tick_s) begin
      pre_cnt_d = 32'd0;
    end else begin
      pre_cnt_d = pre_cnt_q + 32'd1;
    end
  end

  // Ripple BCD increment and decrement of the whole count, with wrap flags.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    carry  = 1'b1;
    borrow = 1'b1;
    d      = 4'd0;
    inc_s  = count_q;
    dec_s  = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      d = count_q[4*i +: 4];
      if (carry) begin
        if (d >= 4'd9) begin
          inc_s[4*i +: 4] = 4'd0;
          carry           = 1'b1;
        end else begin
          inc_s[4*i +: 4] = d + 4'd1;
          carry           = 1'b0;
        end
      end else begin
        inc_s[4*i +: 4] = d;
      end
      if (borrow) begin
        if (d == 4'd0) begin
          dec_s[4*i +: 4] = 4'd9;
          borrow          = 1'b1;
        end else begin
          dec_s[4*i +: 4] = d - 4'd1;
          borrow          = 1'b0;
        end
      end else begin
        dec_s[4*i +: 4] = d;
      end
    end
    inc_wrap_s = carry;
    dec_wrap_s = borrow;
  end

  // Next count: load beats a step; an out-of-range digit_sel matches no digit.
  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    ld_val_s = (bus.load_digit > 4'd9) ? 4'd9 : bus.load_digit;
    if (bus.load) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (i == int'(bus.digit_sel)) begin
          count_d[4*i +: 4] = ld_val_s;
        end else begin
          count_d[4*i +: 4] = count_q[4*i +: 4];
        end
      end
    end else if (tick_s && bus.en) begin
      if (bus.ud) begin
        count_d = inc_s;
        tc_d    = inc_wrap_s;
      end else begin
        count_d = dec_s;
        tc_d    = dec_wrap_s;
      end
    end else begin
      count_d = count_q;
      tc_d    = 1'b0;
    end
  end

  // Scan timer: hold each position SCAN_DIV cycles, then move to the next.
  always_comb begin
    if (scan_cnt_q >= SCAN_LAST) begin
      scan_cnt_d = 32'd0;
      index_d    = (index_q >= IDX_LAST) ? 3'd0 : index_q + 3'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + 32'd1;
      index_d    = index_q;
    end
  end

  // Display decode for the active position from the current index and count.
  always_comb begin
    cur_digit_s = 4'd0;
    msnz_s      = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (3'(i) == index_q) begin
        cur_digit_s = count_q[4*i +: 4];
      end else begin
        cur_digit_s = cur_digit_s;
      end
      if (count_q[4*i +: 4] != 4'd0) begin
        msnz_s = 3'(i);
      end else begin
        msnz_s = msnz_s;
      end
    end
`ifdef LZ_BLANK_EN
    blank_s = (index_q > msnz_s);
`else
    blank_s = 1'b0;
`endif
    if (blank_s) begin
      an_d  = {DIGITS{1'b1}};
      seg_d = 7'b1111111;
    end else begin
      an_d  = ~(DIGITS'(1) << index_q);
      seg_d = seg_decode(cur_digit_s);
    end
    dp_d = ((index_q == 3'd0) && !bus.ud) ? 1'b0 : 1'b1;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q  <= 32'd0;
      count_q    <= {CW{1'b0}};
      tc_q       <= 1'b0;
      scan_cnt_q <= 32'd0;
      index_q    <= 3'd0;
      an_q       <= {{(DIGITS-1){1'b1}}, 1'b0};
      seg_q      <= 7'b1000000;
      dp_q       <= 1'b1;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      count_q    <= count_d;
      tc_q       <= tc_d;
      scan_cnt_q <= scan_cnt_d;
      index_q    <= index_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
endmodule

// File: tb/tb_bcd_updown_display.sv
// Self-checking bench for bcd_updown_display (DIGITS=4, SCAN_DIV=3).
// The reference keeps the count as a plain integer 0..9999 and derives
// digits, wraps and the scanned position arithmetically.
module tb_bcd_updown_display;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 3;
  localparam int MAXV     = 10000;

  logic clk = 1'b0;
  logic rst;

  bcd_updown_display_if #(.DIGITS(DIGITS)) bus ();

  bcd_updown_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_val;
  bit         m_tc;
  longint     m_pre;
  int         m_cyc;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  bit         m_dp;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pow10(input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = 16'd0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  // One clock: advance the model with the inputs seen at this edge, then compare.
  task automatic step();
    int p;
    int dig;
    int sel;
    int nv;
    int old;
    bit tick;
    @(posedge clk);
    if (rst) begin
      m_val = 0; m_tc = 1'b0; m_pre = 0; m_cyc = 0;
      m_an = 4'b1110; m_seg = 7'b1000000; m_dp = 1'b1;
    end else begin
      p     = (m_cyc / SCAN_DIV) % DIGITS;
      dig   = (m_val / pow10(p)) % 10;
      m_an  = 4'b1111;
      m_an[p] = 1'b0;
      m_seg = seg_tab[dig];
`ifdef LZ_BLANK_EN
      if (p > 0 && m_val < pow10(p)) begin
        m_an  = 4'b1111;
        m_seg = 7'b1111111;
      end
`endif
      m_dp  = !(p == 0 && bus.ud == 1'b0);
      m_cyc++;
      tick  = (m_pre >= ((longint'(1) << bus.rate) - 1));
      m_pre = tick ? 0 : m_pre + 1;
      m_tc  = 1'b0;
      if (bus.load) begin
        sel = int'(bus.digit_sel);
        if (sel < DIGITS) begin
          nv    = (bus.load_digit > 4'd9) ? 9 : int'(bus.load_digit);
          old   = (m_val / pow10(sel)) % 10;
          m_val = m_val + (nv - old) * pow10(sel);
        end
      end else if (tick && bus.en) begin
        if (bus.ud) begin
          m_tc  = (m_val == MAXV - 1);
          m_val = (m_val + 1) % MAXV;
        end else begin
          m_tc  = (m_val == 0);
          m_val = (m_val + MAXV - 1) % MAXV;
        end
      end
    end
    #1;
    check_eq("count", 32'(bus.count), 32'(to_bcd(m_val)));
    check_eq("tc",    32'(bus.tc),    32'(m_tc));
    check_eq("an",    32'(bus.an),    32'(m_an));
    check_eq("seg",   32'(bus.seg),   32'(m_seg));
    check_eq("dp",    32'(bus.dp),    32'(m_dp));
  endtask

  // Drive one cycle of inputs on the falling edge, then run the checked edge.
  task automatic cyc(input bit r, input bit e, input bit u, input logic [4:0] rt,
                     input bit ld, input logic [3:0] ldd, input logic [2:0] sel);
    @(negedge clk);
    rst            = r;
    bus.en         = e;
    bus.ud         = u;
    bus.rate       = rt;
    bus.load       = ld;
    bus.load_digit = ldd;
    bus.digit_sel  = sel;
    step();
  endtask

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    rst = 1'b1; bus.en = 1'b1; bus.ud = 1'b1; bus.rate = 5'd2;
    bus.load = 1'b0; bus.load_digit = 4'd0; bus.digit_sel = 3'd0;

    // Reset state
    cyc(1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 4'd0, 3'd0);
    cyc(1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 4'd0, 3'd0);
    check_eq("rst_count", 32'(bus.count), 32'h0);
    check_eq("rst_an",    32'(bus.an),    32'h0000000e);
    check_eq("rst_seg",   32'(bus.seg),   32'h00000040);
    check_eq("rst_dp",    32'(bus.dp),    32'h1);

    // Count up every 4 cycles with rate=2: ten ticks in 40 cycles
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 4'd0, 3'd0);
    check_eq("rate2_count", 32'(bus.count), 32'h0010);

    // Load 9999 then one up tick wraps to 0000 with a single tc pulse
    for (int i = 0; i < DIGITS; i++) cyc(1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 4'd9, 3'(i));
    check_eq("load9999", 32'(bus.count), 32'h9999);
    cyc(1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 4'd0, 3'd0);
    check_eq("wrap_up_count", 32'(bus.count), 32'h0000);
    check_eq("wrap_up_tc",    32'(bus.tc),    32'h1);
    cyc(1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 4'd0, 3'd0);
    check_eq("tc_one_cycle", 32'(bus.tc), 32'h0);

    // Load of 12 into digit 1 during a tick clamps to 9, no step, no tc
    cyc(1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 4'd12, 3'd1);
    check_eq("clamp_count", 32'(bus.count), 32'h0090);
    check_eq("clamp_tc",    32'(bus.tc),    32'h0);

    // Out-of-range digit_sel is ignored
    cyc(1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 4'd5, 3'd6);
    check_eq("badsel_count", 32'(bus.count), 32'h0090);

    // Back to 0000, then one down tick wraps to 9999
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd0, 3'd1);
    cyc(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 4'd0, 3'd0);
    check_eq("wrap_dn_count", 32'(bus.count), 32'h9999);
    check_eq("wrap_dn_tc",    32'(bus.tc),    32'h1);

    // Leading-zero display pattern with 0042 across a full scan
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd0, 3'd3);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd0, 3'd2);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd4, 3'd1);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd2, 3'd0);
    for (int i = 0; i < 2 * SCAN_DIV * DIGITS; i++)
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 3'd0);

    // Randomized traffic with occasional resets and rate changes
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) != 0),
          1'($urandom),
          5'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0),
          4'($urandom_range(0, 15)),
          3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
